elevator_request_scheduler: RTL and testbench
=============================================

Name: elevator_request_scheduler

Overview:
- Upstream feeder for Elevator_Control. Latches hall/car call pulses into a per-floor pending bitmap and drives the floor_request that Elevator_Control consumes.
- Uses SCAN ordering: it keeps servicing calls in the current direction, then reverses.
- Watches current_floor to detect arrival, clears the served call and holds a dwell interval before choosing the next target.

Parameters:
- NUM_FLOORS, 48, number of serviced floors (0..NUM_FLOORS-1); maximum 64.
- FLOOR_W, 6, floor-number width; matches floor_request/current_floor.
- DWELL_CYCLES, 4, clock cycles spent at a served floor before the next target is chosen; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- call_valid  input  1  one-cycle call strobe.
- call_floor  input  FLOOR_W  requested floor, sampled when call_valid=1.
- current_floor  input  FLOOR_W  car position from Elevator_Control.
- floor_request  output  FLOOR_W  target floor to Elevator_Control.
- request_valid  output  1  1 while floor_request is a real pending target.
- dir_up  output  1  scan direction: 1=up, 0=down.
- busy  output  1  1 when state is not IDLE.
- call_reject  output  1  one-cycle pulse, registered, for an out-of-range call.
- pending  output  NUM_FLOORS  pending-call bitmap.

Behaviour:
- Reset (async, reset=0): pending=0, state=IDLE, floor_request=0, request_valid=0, dir_up=1, busy=0, call_reject=0, dwell counter=0. Reset asserted mid-move or mid-dwell discards all calls immediately.
- Call capture:
  - If call_valid=1 and call_floor<NUM_FLOORS, set pending[call_floor] at that edge.
  - If call_floor>=NUM_FLOORS, do not latch; call_reject=1 for the next cycle only.
  - A call to an already-pending floor has no effect.
  - A call equal to current_floor while in IDLE or DWELL is absorbed: no bit set, no reject, and DWELL is not restarted.
- State IDLE:
  - If pending!=0, pick the pending floor nearest current_floor. A distance tie goes to the floor above.
  - Set dir_up accordingly, load floor_request, request_valid=1, go to MOVE.
  - If pending=0, floor_request holds its last value and request_valid=0.
- Latency: a call latched at edge N appears on floor_request at edge N+1 (registered selection).
- State MOVE:
  - Each cycle, recompute the target as the nearest pending floor strictly ahead in dir_up. A new call closer in the same direction retargets floor_request on the next edge.
  - Arrival (current_floor==floor_request): clear pending[floor_request], load dwell counter with DWELL_CYCLES, request_valid=0, go to DWELL. floor_request is held.
  - If a call to the arrival floor lands on the arrival edge, the clear wins.
- State DWELL:
  - Counter decrements each cycle. At 0: pick the next pending floor ahead in dir_up.
  - If none ahead, reverse dir_up and pick the nearest pending floor behind.
  - If pending=0, go to IDLE with dir_up unchanged.
- Wrap-around:
  - Direction never wraps: floor NUM_FLOORS-1 forces a reversal to down, floor 0 forces up.
  - Floor arithmetic is unsigned FLOOR_W with no overflow; distances are computed as a difference, never as modulo.
- busy = (state!=IDLE).

Optional Feature:
- Macro FIRE_RECALL_EN. When defined, adds input port recall (1 bit, level).
- With recall=1:
  - pending is cleared and new calls are ignored (not rejected).
  - floor_request=0, request_valid=1, dir_up=0, state=MOVE.
  - On arrival at floor 0, hold floor_request=0 with request_valid=0 until recall=0, then return to IDLE.
- When the macro is undefined, the port does not exist and behaviour is as above.

Test Plan:
- Reset, release, current_floor=0, call 20 -> next edge floor_request=20, request_valid=1, dir_up=1, busy=1; at current_floor=20: pending[20]=0, request_valid=0, 4 dwell cycles, then IDLE.
- Car at 5 going up to 30; call 12 -> floor_request becomes 12 one cycle later. After dwell at 12, target 30.
- Car at 10, pending {3,17}, direction up -> serves 17, reverses (dir_up=0), serves 3, then IDLE.
- call_floor=50 with NUM_FLOORS=48 -> call_reject=1 for exactly 1 cycle, pending unchanged.
- Calls 8 and 40 pending, car moving to 8; assert reset=0 mid-move -> all outputs at reset values immediately, pending=0. After release, no request is issued.
- FIRE_RECALL_EN: car moving up to 25 from 10, pending {25,33}, raise recall -> pending=0, floor_request=0, dir_up=0. Calls during recall are ignored. Drop recall at floor 0 -> IDLE.

Source files
------------

// File: rtl/elevator_request_scheduler.sv
// SCAN-order call scheduler: latches calls into a pending bitmap and feeds floor_request to Elevator_Control.
// Latency: call latched at edge N drives floor_request at edge N+1; DWELL_CYCLES cycles held at each served floor.
// Backpressure: none (calls are single-cycle strobes); out-of-range calls pulse call_reject. Optional FIRE_RECALL_EN adds recall.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 48,
    parameter int FLOOR_W      = 6,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
`ifdef FIRE_RECALL_EN
    input  logic                  recall,
`endif
    output logic [FLOOR_W-1:0]    floor_request,
    output logic                  request_valid,
    output logic                  dir_up,
    output logic                  busy,
    output logic                  call_reject,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MOVE  = 2'd1;
    localparam logic [1:0] DWELL = 2'd2;
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      dwell_cnt;
    logic                  rec_parked;
    logic                  recall_on;

`ifdef FIRE_RECALL_EN
    assign recall_on = recall;
`else
    assign recall_on = 1'b0;
`endif

    logic                  in_range, absorb, accept, reject, arrive;
    logic [NUM_FLOORS-1:0] set_mask, clr_mask, pending_nxt;
    logic                  up_hit, dn_hit, at_hit;
    logic [FLOOR_W-1:0]    up_floor, dn_floor, up_dist, dn_dist;
    logic [FLOOR_W-1:0]    near_floor, ahead_floor, behind_floor;
    logic                  near_up, ahead_hit, behind_hit;

    assign in_range = ({1'b0, call_floor} < (FLOOR_W + 1)'(NUM_FLOORS));
    // A call for the floor the car is standing at is satisfied by being there.
    assign absorb   = (state == IDLE || state == DWELL) && (call_floor == current_floor);
    assign accept   = call_valid && !recall_on && in_range && !absorb;
    assign reject   = call_valid && !recall_on && !in_range;
    assign arrive   = (state == MOVE) && (current_floor == floor_request);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        up_hit   = 1'b0;
        dn_hit   = 1'b0;
        at_hit   = 1'b0;
        up_floor = '0;
        dn_floor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            set_mask[i] = accept && (call_floor == FLOOR_W'(i));
            clr_mask[i] = arrive && (floor_request == FLOOR_W'(i));
            if (pending[i] && FLOOR_W'(i) == current_floor)
                at_hit = 1'b1;
            if (pending[i] && FLOOR_W'(i) < current_floor) begin
                dn_hit   = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && FLOOR_W'(i) > current_floor) begin
                up_hit   = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
    end

    // Clear applies after set so an arrival-edge call to the same floor is dropped.
    assign pending_nxt = recall_on ? '0 : ((pending | set_mask) & ~clr_mask);

    assign up_dist = up_floor - current_floor;
    assign dn_dist = current_floor - dn_floor;

    always_comb begin
        near_floor = current_floor;
        near_up    = dir_up;
        if (!at_hit) begin
            if (up_hit && (!dn_hit || up_dist <= dn_dist)) begin
                near_floor = up_floor;
                near_up    = 1'b1;
            end else if (dn_hit) begin
                near_floor = dn_floor;
                near_up    = 1'b0;
            end
        end
    end

    assign ahead_hit    = dir_up ? up_hit   : dn_hit;
    assign ahead_floor  = dir_up ? up_floor : dn_floor;
    assign behind_hit   = dir_up ? dn_hit   : up_hit;
    assign behind_floor = dir_up ? dn_floor : up_floor;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pending       <= '0;
            floor_request <= '0;
            request_valid <= 1'b0;
            dir_up        <= 1'b1;
            call_reject   <= 1'b0;
            dwell_cnt     <= '0;
            rec_parked    <= 1'b0;
        end else begin
            call_reject <= reject;
            pending     <= pending_nxt;
            if (recall_on) begin
                state         <= MOVE;
                floor_request <= '0;
                dir_up        <= 1'b0;
                if (current_floor == '0) begin
                    request_valid <= 1'b0;
                    rec_parked    <= 1'b1;
                end else begin
                    request_valid <= 1'b1;
                end
            end else if (rec_parked) begin
                rec_parked    <= 1'b0;
                request_valid <= 1'b0;
                state         <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (|pending) begin
                            floor_request <= near_floor;
                            dir_up        <= near_up;
                            request_valid <= 1'b1;
                            state         <= MOVE;
                        end else begin
                            request_valid <= 1'b0;
                        end
                    end
                    MOVE: begin
                        if (arrive) begin
                            dwell_cnt     <= CNT_W'(DWELL_CYCLES);
                            request_valid <= 1'b0;
                            state         <= DWELL;
                        end else if (ahead_hit) begin
                            floor_request <= ahead_floor;
                        end
                    end
                    DWELL: begin
                        if (dwell_cnt > CNT_W'(1)) begin
                            dwell_cnt <= dwell_cnt - CNT_W'(1);
                        end else begin
                            dwell_cnt <= '0;
                            if (ahead_hit) begin
                                floor_request <= ahead_floor;
                                request_valid <= 1'b1;
                                state         <= MOVE;
                            end else if (behind_hit) begin
                                floor_request <= behind_floor;
                                dir_up        <= ~dir_up;
                                request_valid <= 1'b1;
                                state         <= MOVE;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: table of per-cycle vectors plus a hand-written reset-mid-move sequence.
module tb_elevator_request_scheduler;
    localparam int NF = 48;
    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          call_valid;
    logic [FW-1:0] call_floor;
    logic [FW-1:0] current_floor;
    logic [FW-1:0] floor_request;
    logic          request_valid;
    logic          dir_up;
    logic          busy;
    logic          call_reject;
    logic [NF-1:0] pending;

    elevator_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DWELL_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .current_floor (current_floor),
        .floor_request (floor_request),
        .request_valid (request_valid),
        .dir_up        (dir_up),
        .busy          (busy),
        .call_reject   (call_reject),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          cv;
        logic [FW-1:0] cf;
        logic [FW-1:0] cur;
        logic [57:0]   exp;
    } vec_t;

    vec_t        vecs[$];
    logic [57:0] sb[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [NF-1:0] p(input int n);
        logic [NF-1:0] m;
        m    = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    function automatic logic [57:0] pack_exp(input int req, input logic rv, input logic up,
                                             input logic bz, input logic rej, input logic [NF-1:0] pend);
        return {FW'(req), rv, up, bz, rej, pend};
    endfunction

    task automatic add(input logic cv, input int cf, input int cur, input int req, input logic rv,
                       input logic up, input logic bz, input logic rej, input logic [NF-1:0] pend);
        vec_t v;
        v.cv  = cv;
        v.cf  = FW'(cf);
        v.cur = FW'(cur);
        v.exp = pack_exp(req, rv, up, bz, rej, pend);
        vecs.push_back(v);
    endtask

    task automatic check(input string name);
        logic [57:0] a;
        logic [57:0] e;
        a = {floor_request, request_valid, dir_up, busy, call_reject, pending};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got %h", name, a);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got req=%0d rv=%b up=%b busy=%b rej=%b pend=%h, expected req=%0d rv=%b up=%b busy=%b rej=%b pend=%h",
                         name, a[57:52], a[51], a[50], a[49], a[48], a[47:0],
                         e[57:52], e[51], e[50], e[49], e[48], e[47:0]);
            end
        end
    endtask

    task automatic step(input logic cv, input logic [FW-1:0] cf, input logic [FW-1:0] cur,
                        input logic [57:0] e, input string name);
        @(negedge clk);
        call_valid    = cv;
        call_floor    = cf;
        current_floor = cur;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Single call to 20: serve, dwell 4 cycles, idle.
        add(1, 20, 0,  0, 0, 1, 0, 0, p(20));
        add(0, 0,  0,  20, 1, 1, 1, 0, p(20));
        add(0, 0,  10, 20, 1, 1, 1, 0, p(20));
        add(0, 0,  20, 20, 0, 1, 1, 0, '0);
        for (int i = 0; i < 3; i++) add(0, 0, 20, 20, 0, 1, 1, 0, '0);
        add(0, 0,  20, 20, 0, 1, 0, 0, '0);
        add(0, 0,  20, 20, 0, 1, 0, 0, '0);
        // Moving up to 30, a call to 12 retargets; after dwell resume to 30.
        add(1, 30, 5,  20, 0, 1, 0, 0, p(30));
        add(0, 0,  5,  30, 1, 1, 1, 0, p(30));
        add(1, 12, 6,  30, 1, 1, 1, 0, p(30) | p(12));
        add(0, 0,  7,  12, 1, 1, 1, 0, p(30) | p(12));
        add(0, 0,  12, 12, 0, 1, 1, 0, p(30));
        for (int i = 0; i < 3; i++) add(0, 0, 12, 12, 0, 1, 1, 0, p(30));
        add(0, 0,  12, 30, 1, 1, 1, 0, p(30));
        add(0, 0,  30, 30, 0, 1, 1, 0, '0);
        for (int i = 0; i < 3; i++) add(0, 0, 30, 30, 0, 1, 1, 0, '0);
        add(0, 0,  30, 30, 0, 1, 0, 0, '0);
        // Car at 10 going up with {3,17}: serve 17, reverse, serve 3.
        add(1, 17, 10, 30, 0, 1, 0, 0, p(17));
        add(1, 3,  10, 17, 1, 1, 1, 0, p(17) | p(3));
        add(0, 0,  17, 17, 0, 1, 1, 0, p(3));
        for (int i = 0; i < 3; i++) add(0, 0, 17, 17, 0, 1, 1, 0, p(3));
        add(0, 0,  17, 3,  1, 0, 1, 0, p(3));
        add(0, 0,  3,  3,  0, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) add(0, 0, 3, 3, 0, 0, 1, 0, '0);
        add(0, 0,  3,  3,  0, 0, 0, 0, '0);
        // Out-of-range rejects, top floor, duplicate call, absorbed call in dwell.
        add(1, 50, 3,  3,  0, 0, 0, 1, '0);
        add(0, 0,  3,  3,  0, 0, 0, 0, '0);
        add(1, 48, 3,  3,  0, 0, 0, 1, '0);
        add(1, 47, 3,  3,  0, 0, 0, 0, p(47));
        add(0, 0,  3,  47, 1, 1, 1, 0, p(47));
        add(1, 47, 20, 47, 1, 1, 1, 0, p(47));
        add(0, 0,  47, 47, 0, 1, 1, 0, '0);
        add(1, 47, 47, 47, 0, 1, 1, 0, '0);
        for (int i = 0; i < 2; i++) add(0, 0, 47, 47, 0, 1, 1, 0, '0);
        add(0, 0,  47, 47, 0, 1, 0, 0, '0);
        // Floor 0 from the top; arrival-edge call to the same floor is cleared.
        add(1, 0,  47, 47, 0, 1, 0, 0, p(0));
        add(0, 0,  47, 0,  1, 0, 1, 0, p(0));
        add(1, 0,  0,  0,  0, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 0, '0);
        add(0, 0,  0,  0,  0, 0, 0, 0, '0);
        add(1, 0,  0,  0,  0, 0, 0, 0, '0);

        reset         = 1'b0;
        call_valid    = 1'b0;
        call_floor    = '0;
        current_floor = '0;
        #12;
        sb.push_back(pack_exp(0, 0, 1, 0, 0, '0));
        check("reset_state");
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i])
            step(vecs[i].cv, vecs[i].cf, vecs[i].cur, vecs[i].exp, $sformatf("row%0d", i));

        // Reset asserted mid-move with calls 8 and 40 pending.
        step(1, FW'(8),  FW'(0), pack_exp(0, 0, 0, 0, 0, p(8)), "mid_call8");
        step(1, FW'(40), FW'(0), pack_exp(8, 1, 1, 1, 0, p(8) | p(40)), "mid_call40");
        step(0, FW'(0),  FW'(3), pack_exp(8, 1, 1, 1, 0, p(8) | p(40)), "mid_move");
        #2;
        reset = 1'b0;
        #1;
        sb.push_back(pack_exp(0, 0, 1, 0, 0, '0));
        check("async_reset");
        @(posedge clk);
        #1;
        sb.push_back(pack_exp(0, 0, 1, 0, 0, '0));
        check("reset_hold");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            step(0, FW'(0), FW'(3), pack_exp(0, 0, 1, 0, 0, '0), $sformatf("post_reset%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
